// File: rtl/tinygpu_pkg.sv
// Shared framebuffer geometry and receiver state encoding.
package tinygpu_pkg;

  localparam int unsigned FB_W      = 8;
  localparam int unsigned FB_H      = 8;
  localparam int unsigned PIX_BITS  = 4;
  localparam int unsigned CNT_BITS  = 8;
  localparam int unsigned FB_PIXELS = FB_W * FB_H;
  localparam int unsigned FB_AW     = $clog2(FB_PIXELS);

  typedef enum logic {
    RX_IDLE,
    RX_CAPTURE
  } rx_state_t;

endpackage

// File: rtl/fb_bank.sv
// One framebuffer bank: register array with one write port and one
// combinational read port, cleared by synchronous reset.
module fb_bank
  import tinygpu_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [FB_AW-1:0]    waddr,
  input  logic [PIX_BITS-1:0] wdata,
  input  logic [FB_AW-1:0]    raddr,
  output logic [PIX_BITS-1:0] rdata
);

  logic [PIX_BITS-1:0] mem_q [FB_PIXELS];
  logic [PIX_BITS-1:0] mem_d [FB_PIXELS];

  // Next array contents: a single cell updated on write.
  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[waddr] = wdata;
    end
  end

  // Array state with synchronous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '{default: '0};
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/pixel_stream_receiver.sv
// Reassembles the serial pixel stream into a double-buffered framebuffer.
// Pixels land in the back bank; a full 64-pixel frame swaps banks so the
// readback port always sees a complete frame.
module pixel_stream_receiver
  import tinygpu_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [PIX_BITS-1:0] pixel_data,
  input  logic                frame_sync,
  input  logic [FB_AW-1:0]    rd_addr,
  output logic [PIX_BITS-1:0] rd_data,
  output logic                frame_done,
  output logic [CNT_BITS-1:0] frame_count,
  output logic                err_short,
  output logic                busy
);

  localparam logic [FB_AW-1:0] LastIdx = FB_AW'(FB_PIXELS - 1);

  rx_state_t           state_q, state_d;
  logic [FB_AW-1:0]    wr_idx_q, wr_idx_d;
  logic                front_sel_q, front_sel_d;
  logic                frame_done_q, frame_done_d;
  logic [CNT_BITS-1:0] frame_count_q, frame_count_d;
  logic                err_short_q, err_short_d;
  logic                busy_q, busy_d;
  logic [PIX_BITS-1:0] rd_data_q, rd_data_d;

  logic                we;
  logic [FB_AW-1:0]    waddr;
  logic [PIX_BITS-1:0] bank0_rdata, bank1_rdata;

  // Capture FSM: sync always restarts at index 0; index 63 completes and swaps.
  always_comb begin
    state_d       = state_q;
    wr_idx_d      = wr_idx_q;
    front_sel_d   = front_sel_q;
    frame_done_d  = 1'b0;
    frame_count_d = frame_count_q;
    err_short_d   = err_short_q;
    we            = 1'b0;
    waddr         = wr_idx_q;
    unique case (state_q)
      RX_IDLE: begin
        if (frame_sync) begin
          we       = 1'b1;
          waddr    = '0;
          wr_idx_d = FB_AW'(1);
          state_d  = RX_CAPTURE;
        end
      end
      RX_CAPTURE: begin
        we = 1'b1;
        if (frame_sync) begin
          // Sync before the frame filled: restart without swapping.
          waddr       = '0;
          wr_idx_d    = FB_AW'(1);
          err_short_d = 1'b1;
        end else if (wr_idx_q == LastIdx) begin
          front_sel_d   = ~front_sel_q;
          frame_done_d  = 1'b1;
          frame_count_d = frame_count_q + CNT_BITS'(1);
          wr_idx_d      = '0;
          state_d       = RX_IDLE;
        end else begin
          wr_idx_d = wr_idx_q + FB_AW'(1);
        end
      end
    endcase
    busy_d    = (state_d == RX_CAPTURE);
    // Uses the pre-swap select, so a read in the swap cycle sees the old frame.
    rd_data_d = front_sel_q ? bank1_rdata : bank0_rdata;
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RX_IDLE;
      wr_idx_q      <= '0;
      front_sel_q   <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_count_q <= '0;
      err_short_q   <= 1'b0;
      busy_q        <= 1'b0;
      rd_data_q     <= '0;
    end else begin
      state_q       <= state_d;
      wr_idx_q      <= wr_idx_d;
      front_sel_q   <= front_sel_d;
      frame_done_q  <= frame_done_d;
      frame_count_q <= frame_count_d;
      err_short_q   <= err_short_d;
      busy_q        <= busy_d;
      rd_data_q     <= rd_data_d;
    end
  end

  // Back bank is the one not selected as front.
  fb_bank u_bank0 (
    .clk   (clk),
    .rst   (rst),
    .we    (we & front_sel_q),
    .waddr (waddr),
    .wdata (pixel_data),
    .raddr (rd_addr),
    .rdata (bank0_rdata)
  );

  fb_bank u_bank1 (
    .clk   (clk),
    .rst   (rst),
    .we    (we & ~front_sel_q),
    .waddr (waddr),
    .wdata (pixel_data),
    .raddr (rd_addr),
    .rdata (bank1_rdata)
  );

  assign rd_data     = rd_data_q;
  assign frame_done  = frame_done_q;
  assign frame_count = frame_count_q;
  assign err_short   = err_short_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_pixel_stream_receiver.sv
// Bench for pixel_stream_receiver: frame model plus readback scoreboard.
module tb_pixel_stream_receiver;
  import tinygpu_pkg::*;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [PIX_BITS-1:0] pixel_data = '0;
  logic                frame_sync = 1'b0;
  logic [FB_AW-1:0]    rd_addr = '0;
  logic [PIX_BITS-1:0] rd_data;
  logic                frame_done;
  logic [CNT_BITS-1:0] frame_count;
  logic                err_short;
  logic                busy;

  pixel_stream_receiver dut (
    .clk         (clk),
    .rst         (rst),
    .pixel_data  (pixel_data),
    .frame_sync  (frame_sync),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .frame_done  (frame_done),
    .frame_count (frame_count),
    .err_short   (err_short),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // Model of the visible frame, the frame being filled, and the frame counter.
  logic [PIX_BITS-1:0] exp_front [FB_PIXELS];
  logic [PIX_BITS-1:0] exp_back  [FB_PIXELS];
  logic [CNT_BITS-1:0] exp_count = '0;
  logic [PIX_BITS-1:0] rd_q [$];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // frame_done is high for a whole cycle, so each pulse is seen at one negedge.
  int done_cnt = 0;
  int done_cyc [$];
  always @(negedge clk) begin
    if (frame_done === 1'b1) begin
      done_cnt++;
      done_cyc.push_back(cyc);
    end
  end

  function automatic logic [PIX_BITS-1:0] pat(input int kind, input int idx, input int seed);
    case (kind)
      0:       return PIX_BITS'(idx % 16);
      1:       return PIX_BITS'(15 - (idx % 16));
      default: return PIX_BITS'((idx * 7 + seed) % 16);
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < int'(FB_PIXELS); i++) begin
      exp_front[i] = '0;
      exp_back[i]  = '0;
    end
    exp_count = '0;
  endtask

  // Pixels 0..62 of a frame, sync on pixel 0.
  task automatic drive_body(input int kind, input int seed);
    for (int i = 0; i < int'(FB_PIXELS) - 1; i++) begin
      frame_sync  = (i == 0);
      pixel_data  = pat(kind, i, seed);
      exp_back[i] = pixel_data;
      step();
    end
    frame_sync = 1'b0;
  endtask

  // Pixel 63: completes the frame and swaps banks in the model.
  task automatic drive_last(input int kind, input int seed);
    frame_sync = 1'b0;
    pixel_data = pat(kind, int'(FB_PIXELS) - 1, seed);
    exp_back[FB_PIXELS-1] = pixel_data;
    step();
    for (int i = 0; i < int'(FB_PIXELS); i++) exp_front[i] = exp_back[i];
    exp_count = exp_count + CNT_BITS'(1);
  endtask

  task automatic send_frame(input int kind, input int seed);
    drive_body(kind, seed);
    drive_last(kind, seed);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    frame_sync = 1'b0;
    step();
    step();
    rst = 1'b0;
    model_clear();
    n_total++;
    if (frame_done !== 1'b0) $display("FAIL reset_done: got %b want 0", frame_done);
    else n_pass++;
    n_total++;
    if (frame_count !== '0) $display("FAIL reset_count: got %0d want 0", frame_count);
    else n_pass++;
    n_total++;
    if (err_short !== 1'b0) $display("FAIL reset_err: got %b want 0", err_short);
    else n_pass++;
    n_total++;
    if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy);
    else n_pass++;
    n_total++;
    if (rd_data !== '0) $display("FAIL reset_rd: got %0d want 0", rd_data);
    else n_pass++;
  endtask

  task automatic test_first_frame();
    logic [PIX_BITS-1:0] e;
    drive_body(0, 0);
    n_total++;
    if (busy !== 1'b1) $display("FAIL first_busy: got %b want 1", busy);
    else n_pass++;
    drive_last(0, 0);
    n_total++;
    if (frame_done !== 1'b1) $display("FAIL first_done: got %b want 1", frame_done);
    else n_pass++;
    n_total++;
    if (frame_count !== CNT_BITS'(1)) $display("FAIL first_count: got %0d want 1", frame_count);
    else n_pass++;
    n_total++;
    if (busy !== 1'b0) $display("FAIL first_idle: got %b want 0", busy);
    else n_pass++;
    rd_addr = FB_AW'(37);
    rd_q.push_back(PIX_BITS'(5));
    step();
    e = rd_q.pop_front();
    n_total++;
    if (rd_data !== e) $display("FAIL first_rd37: got %0d want %0d", rd_data, e);
    else n_pass++;
    n_total++;
    if (frame_done !== 1'b0) $display("FAIL first_pulse: got %b want 0", frame_done);
    else n_pass++;
    n_total++;
    if (err_short !== 1'b0) $display("FAIL first_err: got %b want 0", err_short);
    else n_pass++;
    for (int a = 0; a < int'(FB_PIXELS); a += 9) begin
      rd_addr = FB_AW'(a);
      rd_q.push_back(exp_front[a]);
      step();
      e = rd_q.pop_front();
      n_total++;
      if (rd_data !== e) $display("FAIL first_rd[%0d]: got %0d want %0d", a, rd_data, e);
      else n_pass++;
    end
  endtask

  task automatic test_swap_read();
    logic [PIX_BITS-1:0] e;
    drive_body(1, 0);
    rd_addr = '0;
    rd_q.push_back(PIX_BITS'(0));
    drive_last(1, 0);
    e = rd_q.pop_front();
    n_total++;
    if (rd_data !== e) $display("FAIL swap_old: got %0d want %0d", rd_data, e);
    else n_pass++;
    rd_q.push_back(PIX_BITS'(15));
    step();
    e = rd_q.pop_front();
    n_total++;
    if (rd_data !== e) $display("FAIL swap_new: got %0d want %0d", rd_data, e);
    else n_pass++;
    n_total++;
    if (frame_count !== CNT_BITS'(2)) $display("FAIL swap_count: got %0d want 2", frame_count);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int d0, q0;
    logic [PIX_BITS-1:0] e;
    d0 = done_cnt;
    q0 = done_cyc.size();
    for (int f = 0; f < 3; f++) send_frame(2, 3 + f);
    step();
    n_total++;
    if (done_cnt - d0 !== 3) $display("FAIL b2b_pulses: got %0d want 3", done_cnt - d0);
    else n_pass++;
    if (done_cyc.size() >= q0 + 3) begin
      for (int k = 1; k < 3; k++) begin
        n_total++;
        if (done_cyc[q0+k] - done_cyc[q0+k-1] !== 64)
          $display("FAIL b2b_spacing%0d: got %0d want 64", k,
                   done_cyc[q0+k] - done_cyc[q0+k-1]);
        else n_pass++;
      end
    end
    n_total++;
    if (err_short !== 1'b0) $display("FAIL b2b_err: got %b want 0", err_short);
    else n_pass++;
    n_total++;
    if (frame_count !== exp_count) $display("FAIL b2b_count: got %0d want %0d", frame_count, exp_count);
    else n_pass++;
    for (int a = 3; a < int'(FB_PIXELS); a += 12) begin
      rd_addr = FB_AW'(a);
      rd_q.push_back(exp_front[a]);
      step();
      e = rd_q.pop_front();
      n_total++;
      if (rd_data !== e) $display("FAIL b2b_rd[%0d]: got %0d want %0d", a, rd_data, e);
      else n_pass++;
    end
  endtask

  task automatic test_idle_gap();
    int d0;
    logic [PIX_BITS-1:0] e;
    d0 = done_cnt;
    frame_sync = 1'b0;
    for (int i = 0; i < 100; i++) begin
      pixel_data = PIX_BITS'($urandom_range(15, 0));
      rd_addr    = FB_AW'(i % 64);
      rd_q.push_back(exp_front[i % 64]);
      step();
      e = rd_q.pop_front();
      if (i % 20 == 0) begin
        n_total++;
        if (rd_data !== e) $display("FAIL idle_rd[%0d]: got %0d want %0d", i % 64, rd_data, e);
        else n_pass++;
      end
    end
    n_total++;
    if (done_cnt !== d0) $display("FAIL idle_pulses: got %0d want %0d", done_cnt, d0);
    else n_pass++;
    n_total++;
    if (frame_count !== exp_count) $display("FAIL idle_count: got %0d want %0d", frame_count, exp_count);
    else n_pass++;
    n_total++;
    if (busy !== 1'b0) $display("FAIL idle_busy: got %b want 0", busy);
    else n_pass++;
    send_frame(2, 11);
    step();
    n_total++;
    if (done_cnt - d0 !== 1) $display("FAIL idle_after: got %0d want 1", done_cnt - d0);
    else n_pass++;
  endtask

  task automatic test_short_frame();
    int d0;
    logic [PIX_BITS-1:0] e;
    d0 = done_cnt;
    for (int i = 0; i < 20; i++) begin
      frame_sync = (i == 0);
      pixel_data = pat(2, i, 5);
      step();
    end
    send_frame(2, 9);
    n_total++;
    if (err_short !== 1'b1) $display("FAIL short_err: got %b want 1", err_short);
    else n_pass++;
    for (int i = 0; i < 10; i++) step();
    n_total++;
    if (err_short !== 1'b1) $display("FAIL short_sticky: got %b want 1", err_short);
    else n_pass++;
    n_total++;
    if (done_cnt - d0 !== 1) $display("FAIL short_pulses: got %0d want 1", done_cnt - d0);
    else n_pass++;
    n_total++;
    if (frame_count !== exp_count) $display("FAIL short_count: got %0d want %0d", frame_count, exp_count);
    else n_pass++;
    for (int a = 0; a < int'(FB_PIXELS); a++) begin
      rd_addr = FB_AW'(a);
      rd_q.push_back(exp_front[a]);
      step();
      e = rd_q.pop_front();
      n_total++;
      if (rd_data !== e) $display("FAIL short_rd[%0d]: got %0d want %0d", a, rd_data, e);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    logic [PIX_BITS-1:0] e;
    for (int i = 0; i < 30; i++) begin
      frame_sync = (i == 0);
      pixel_data = pat(0, i, 0);
      step();
    end
    frame_sync = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_clear();
    n_total++;
    if ({rd_data, frame_done, frame_count, err_short, busy} !== '0)
      $display("FAIL midrst_outs: got rd=%0d done=%b cnt=%0d err=%b busy=%b want all 0",
               rd_data, frame_done, frame_count, err_short, busy);
    else n_pass++;
    for (int a = 0; a < int'(FB_PIXELS); a++) begin
      rd_addr = FB_AW'(a);
      rd_q.push_back(exp_front[a]);
      step();
      e = rd_q.pop_front();
      n_total++;
      if (rd_data !== e) $display("FAIL midrst_rd[%0d]: got %0d want %0d", a, rd_data, e);
      else n_pass++;
    end
    send_frame(2, 1);
    n_total++;
    if (frame_done !== 1'b1) $display("FAIL midrst_done: got %b want 1", frame_done);
    else n_pass++;
    n_total++;
    if (frame_count !== CNT_BITS'(1)) $display("FAIL midrst_count: got %0d want 1", frame_count);
    else n_pass++;
    for (int a = 1; a < int'(FB_PIXELS); a += 7) begin
      rd_addr = FB_AW'(a);
      rd_q.push_back(exp_front[a]);
      step();
      e = rd_q.pop_front();
      n_total++;
      if (rd_data !== e) $display("FAIL midrst_frame[%0d]: got %0d want %0d", a, rd_data, e);
      else n_pass++;
    end
  endtask

  task automatic test_wrap();
    int d0;
    logic [PIX_BITS-1:0] e;
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_clear();
    d0 = done_cnt;
    for (int f = 0; f < 256; f++) begin
      send_frame(2, f);
      if (f == 254) begin
        n_total++;
        if (frame_count !== CNT_BITS'(255)) $display("FAIL wrap_255: got %0d want 255", frame_count);
        else n_pass++;
      end
    end
    n_total++;
    if (frame_count !== '0) $display("FAIL wrap_zero: got %0d want 0", frame_count);
    else n_pass++;
    n_total++;
    if (frame_done !== 1'b1) $display("FAIL wrap_done: got %b want 1", frame_done);
    else n_pass++;
    step();
    n_total++;
    if (done_cnt - d0 !== 256) $display("FAIL wrap_pulses: got %0d want 256", done_cnt - d0);
    else n_pass++;
    rd_addr = FB_AW'(50);
    rd_q.push_back(exp_front[50]);
    step();
    e = rd_q.pop_front();
    n_total++;
    if (rd_data !== e) $display("FAIL wrap_rd: got %0d want %0d", rd_data, e);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_swap_read();
    test_back_to_back();
    test_idle_gap();
    test_short_frame();
    test_reset_mid();
    test_wrap();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
